mips_data_ram: RTL and testbench
================================

Name: mips_data_ram

Overview:
Data-memory responder for the data port of mips_cpu_harvard, serving the CPU's data_address, data_read, data_write, data_writedata and data_readdata signals. Reads are combinational. Writes take effect at a single rising edge. After reset the block runs a sequential clear sweep before it accepts accesses. It keeps sticky error flags and saturating access counters, so benches and the top level can check the CPU's memory traffic.

Parameters:
DATA_BASE, 32'h00000000, byte address of word 0 of the data window
DEPTH_WORDS, 256, number of 32-bit words stored (power of two, at least 4)
CNT_W, 16, width of the read and write access counters

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset
data_address  input  32  byte address from the CPU
data_read  input  1  read request (combinational response)
data_write  input  1  write request (committed at the next rising edge)
data_writedata  input  32  write data
data_readdata  output  32  read data
ready  output  1  high once the clear sweep has finished
err_flags  output  3  sticky errors: [0] misaligned, [1] out of range, [2] read and write asserted together
err_clear  input  1  one-cycle pulse that clears err_flags
read_count  output  CNT_W  number of accepted reads, saturating
write_count  output  CNT_W  number of accepted writes, saturating

Behaviour:
- Reset (reset=0, asynchronous): state=CLEAR, clear index=0, ready=0, err_flags=0, read_count=0, write_count=0, data_readdata=0. Reset asserted mid-sweep or mid-operation restarts the sweep from index 0.
- FSM has two states, CLEAR and READY.
  - CLEAR: writes mem[index]=0 on each edge and increments index. On the edge that clears index DEPTH_WORDS-1 it moves to READY.
  - ready rises exactly DEPTH_WORDS rising edges after reset is released.
  - READY: remains there until the next reset.
- While in CLEAR: CPU reads return 0, writes are ignored, no error flags are set, counters do not change.
- Address decode: off = data_address - DATA_BASE (32-bit, wraps modulo 2^32); idx = off[log2(DEPTH_WORDS)+1:2].
  - misaligned: data_address[1:0] != 0.
  - out of range: off >= DEPTH_WORDS*4.
  - valid: neither misaligned nor out of range.
- Read (READY, data_read=1, data_write=0, valid): data_readdata = mem[idx] combinationally in the same cycle. read_count increments at the next edge.
- In every other case, data_readdata = 0.
- Write (READY, data_write=1, data_read=0, valid): mem[idx] = data_writedata at the rising edge. write_count increments at the same edge.
- Read-after-write to the same address returns the new value from the following cycle onward.
- Conflict (data_read=1 and data_write=1): no write, data_readdata=0, err_flags[2] set at the edge, neither counter changes.
- Invalid address with a request in READY: access ignored, data_readdata=0, the matching flag bit set at the edge.
  - A misaligned address that is also out of range sets both [0] and [1].
- err_flags bits are sticky until err_clear=1 at an edge. If err_clear and a new error occur in the same cycle, the new error's bit is set; the other bits clear.
- Counters saturate at all-ones and do not wrap.
- No request asserted: no state change; data_readdata=0.

Test Plan:
- Release reset with DEPTH_WORDS=256 -> ready=0 for 256 edges and 1 after the 256th; read of 0x00 after that returns 0x00000000.
- Write 0xC0000000 to 0xE0, then read 0xE0 on the next cycle -> readdata=0xC0000000; write_count=1, read_count=1.
- Write to 0x82 -> memory unchanged, err_flags=3'b001. Pulse err_clear -> err_flags=0.
- Read 0x400 -> readdata=0, err_flags=3'b010. Read 0x402 -> err_flags=3'b011.
- Assert data_read and data_write together at 0x10 with writedata 0x55 -> mem[0x10] unchanged, err_flags[2]=1, counters unchanged.
- Assert reset at sweep index 100, release it -> ready returns only after 256 more edges. Drive 70000 valid reads with CNT_W=16 -> read_count holds at 0xFFFF.

Source files
------------

// File: rtl/mips_data_ram.sv
// -----------------------------------------------------------------------------
// mips_data_ram
//   Data-memory responder for the data port of mips_cpu_harvard.
//   After reset a sequential sweep writes zero into every word. Only then does
//   the block serve CPU accesses. Reads are combinational and writes commit on
//   the rising edge. Sticky error flags and saturating access counters make the
//   CPU's memory traffic observable.
//
// Ports
//   clk            : system clock, all state changes on the rising edge
//   reset          : asynchronous, active-low reset
//   data_address   : CPU byte address
//   data_read      : read request, answered in the same cycle
//   data_write     : write request, committed at the next rising edge
//   data_writedata : write data
//   data_readdata  : read data, zero unless a valid read is being served
//   ready          : high once the clear sweep has finished
//   err_flags      : sticky [0] misaligned, [1] out of range, [2] rd+wr conflict
//   err_clear      : one-cycle pulse that clears err_flags
//   read_count     : accepted reads, saturating at all-ones
//   write_count    : accepted writes, saturating at all-ones
//   dbg_state      : FSM state (0 = CLEAR, 1 = READY)
//
// Handshake: there is no back-pressure. A request is sampled in every cycle in
// which data_read or data_write is high. A read is answered combinationally in
// that same cycle. A write takes effect at the rising edge that ends the cycle.
// -----------------------------------------------------------------------------
module mips_data_ram #(
    parameter logic [31:0] DATA_BASE   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      data_address,
    input  logic             data_read,
    input  logic             data_write,
    input  logic [31:0]      data_writedata,
    output logic [31:0]      data_readdata,
    output logic             ready,
    output logic [2:0]       err_flags,
    input  logic             err_clear,
    output logic [CNT_W-1:0] read_count,
    output logic [CNT_W-1:0] write_count,
    output logic             dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [AW-1:0]    r_clr_idx;
    logic [31:0]      r_mem [DEPTH_WORDS];
    logic [2:0]       r_err_flags;
    logic [CNT_W-1:0] r_read_count;
    logic [CNT_W-1:0] r_write_count;

    logic [31:0]      w_off;
    logic [AW-1:0]    w_idx;
    logic             w_misaligned;
    logic             w_out_of_range;
    logic             w_valid;
    logic             w_active;
    logic             w_req;
    logic             w_conflict;
    logic             w_rd_ok;
    logic             w_wr_ok;
    logic [2:0]       w_err_new;
    logic             w_mem_we;
    logic [AW-1:0]    w_mem_addr;
    logic [31:0]      w_mem_wdata;

    // Address decode. The subtraction wraps modulo 2^32, so an address below
    // DATA_BASE turns into a huge offset and is reported as out of range.
    assign w_off          = data_address - DATA_BASE;
    assign w_idx          = w_off[AW+1:2];
    assign w_misaligned   = |data_address[1:0];
    assign w_out_of_range = |w_off[31:AW+2];
    assign w_valid        = !w_misaligned && !w_out_of_range;

    assign w_active   = (r_state == ST_READY);
    assign w_req      = data_read | data_write;
    assign w_conflict = data_read & data_write;
    assign w_rd_ok    = w_active && data_read && !data_write && w_valid;
    assign w_wr_ok    = w_active && data_write && !data_read && w_valid;

    // Errors are only recorded once the sweep is done.
    assign w_err_new = (w_active && w_req) ?
                       {w_conflict, w_out_of_range, w_misaligned} : 3'b000;

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state. READY is terminal until the next reset.
    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_CLEAR && r_clr_idx == AW'(DEPTH_WORDS - 1)) begin
            w_state_next = ST_READY;
        end
    end

    // FSM: outputs
    always_comb begin
        ready     = (r_state == ST_READY);
        dbg_state = r_state;
    end

    // Clear sweep index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clr_idx <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_idx <= r_clr_idx + 1'b1;
        end
    end

    // A single write port is shared by the sweep and the CPU. The two never
    // overlap because CPU writes are gated on READY.
    always_comb begin
        w_mem_we    = w_wr_ok;
        w_mem_addr  = w_idx;
        w_mem_wdata = data_writedata;
        if (r_state == ST_CLEAR) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_clr_idx;
            w_mem_wdata = '0;
        end
    end

    // The storage array has no reset; the sweep provides the cleared contents.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    assign data_readdata = w_rd_ok ? r_mem[w_idx] : 32'h0000_0000;

    // Sticky error flags. A clear in the same cycle as a new error keeps only
    // the new error's bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_flags <= 3'b000;
        end else if (err_clear) begin
            r_err_flags <= w_err_new;
        end else begin
            r_err_flags <= r_err_flags | w_err_new;
        end
    end

    // Saturating access counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_read_count  <= '0;
            r_write_count <= '0;
        end else begin
            if (w_rd_ok && r_read_count != '1) begin
                r_read_count <= r_read_count + 1'b1;
            end
            if (w_wr_ok && r_write_count != '1) begin
                r_write_count <= r_write_count + 1'b1;
            end
        end
    end

    assign err_flags   = r_err_flags;
    assign read_count  = r_read_count;
    assign write_count = r_write_count;

endmodule

// File: tb/tb_mips_data_ram.sv
module tb_mips_data_ram;

  localparam int CNT_W = 16;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]      data_address = '0;
  logic             data_read = 1'b0;
  logic             data_write = 1'b0;
  logic [31:0]      data_writedata = '0;
  logic [31:0]      data_readdata;
  logic             ready;
  logic [2:0]       err_flags;
  logic             err_clear = 1'b0;
  logic [CNT_W-1:0] read_count;
  logic [CNT_W-1:0] write_count;
  logic             dbg_state;

  mips_data_ram #(
    .DATA_BASE   (32'h0000_0000),
    .DEPTH_WORDS (256),
    .CNT_W       (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .data_address   (data_address),
    .data_read      (data_read),
    .data_write     (data_write),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata),
    .ready          (ready),
    .err_flags      (err_flags),
    .err_clear      (err_clear),
    .read_count     (read_count),
    .write_count    (write_count),
    .dbg_state      (dbg_state)
  );

  int n_total = 0;
  int n_bad = 0;
  logic [31:0] exp_rd = 0;
  logic [31:0] exp_wr = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver: called at posedge+1. Holds the request for one cycle, samples the
  // combinational read data mid-cycle, then returns to idle at posedge+1.
  logic [31:0] rd_sample;
  task automatic access(input logic [31:0] addr, input logic rd, input logic wr,
                        input logic [31:0] wd, input logic clr);
    data_address   = addr;
    data_read      = rd;
    data_write     = wr;
    data_writedata = wd;
    err_clear      = clr;
    #3;
    rd_sample = data_readdata;
    @(posedge clk);
    #1;
    data_read  = 1'b0;
    data_write = 1'b0;
    err_clear  = 1'b0;
  endtask

  // Counts edges after reset release. ready must stay low for the first 255
  // edges and be high after the 256th.
  task automatic wait_sweep(input string tag);
    logic early;
    early = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      if (i < 255 && ready !== 1'b0) early = 1'b1;
    end
    check_eq({tag, "_ready_early"}, {31'b0, early}, 32'd0);
    check_eq({tag, "_ready_256"}, {31'b0, ready}, 32'd1);
  endtask

  initial begin
    // reset state
    #12;
    check_eq("rst_ready", {31'b0, ready}, 32'd0);
    check_eq("rst_err", {29'b0, err_flags}, 32'd0);
    check_eq("rst_rdcnt", {16'b0, read_count}, 32'd0);
    check_eq("rst_wrcnt", {16'b0, write_count}, 32'd0);
    check_eq("rst_rdata", data_readdata, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Reads and writes during the sweep are ignored.
    data_address   = 32'h10;
    data_write     = 1'b1;
    data_writedata = 32'hFFFF_FFFF;
    wait_sweep("sweep1");
    data_write = 1'b0;
    check_eq("sweep_wrcnt", {16'b0, write_count}, 32'd0);
    check_eq("sweep_err", {29'b0, err_flags}, 32'd0);

    access(32'h00, 1'b1, 1'b0, 0, 1'b0); exp_rd++;
    check_eq("rd_00", rd_sample, 32'h0);
    access(32'h10, 1'b1, 1'b0, 0, 1'b0); exp_rd++;
    check_eq("rd_10_cleared", rd_sample, 32'h0);

    // write then read back
    access(32'hE0, 1'b0, 1'b1, 32'hC000_0000, 1'b0); exp_wr++;
    access(32'hE0, 1'b1, 1'b0, 0, 1'b0); exp_rd++;
    check_eq("rd_E0", rd_sample, 32'hC000_0000);
    check_eq("wrcnt_1", {16'b0, write_count}, exp_wr);
    check_eq("rdcnt_a", {16'b0, read_count}, exp_rd);

    // last word of the window
    access(32'h3FC, 1'b0, 1'b1, 32'h1234_5678, 1'b0); exp_wr++;
    access(32'h3FC, 1'b1, 1'b0, 0, 1'b0); exp_rd++;
    check_eq("rd_3FC", rd_sample, 32'h1234_5678);

    // misaligned write: no memory change, flag 0
    access(32'h82, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    check_eq("mis_err", {29'b0, err_flags}, 32'b001);
    access(32'h80, 1'b1, 1'b0, 0, 1'b0); exp_rd++;
    check_eq("mis_mem80", rd_sample, 32'h0);
    check_eq("mis_wrcnt", {16'b0, write_count}, exp_wr);
    access(32'h0, 1'b0, 1'b0, 0, 1'b1);
    check_eq("clr_err", {29'b0, err_flags}, 32'b000);

    // out of range, then out of range and misaligned
    access(32'h400, 1'b1, 1'b0, 0, 1'b0);
    check_eq("oor_rdata", rd_sample, 32'h0);
    check_eq("oor_err", {29'b0, err_flags}, 32'b010);
    access(32'h402, 1'b1, 1'b0, 0, 1'b0);
    check_eq("oor_mis_err", {29'b0, err_flags}, 32'b011);
    check_eq("oor_rdcnt", {16'b0, read_count}, exp_rd);
    access(32'h0, 1'b0, 1'b0, 0, 1'b1);

    // read/write conflict
    access(32'h10, 1'b1, 1'b1, 32'h55, 1'b0);
    check_eq("conf_rdata", rd_sample, 32'h0);
    check_eq("conf_err", {29'b0, err_flags}, 32'b100);
    check_eq("conf_rdcnt", {16'b0, read_count}, exp_rd);
    check_eq("conf_wrcnt", {16'b0, write_count}, exp_wr);
    access(32'h10, 1'b1, 1'b0, 0, 1'b0); exp_rd++;
    check_eq("conf_mem10", rd_sample, 32'h0);

    // clear together with a new error keeps only the new bit
    access(32'h81, 1'b0, 1'b1, 32'h1, 1'b1);
    check_eq("clr_new_err", {29'b0, err_flags}, 32'b001);

    // asynchronous reset mid-operation
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_ready", {31'b0, ready}, 32'd0);
    check_eq("arst_err", {29'b0, err_flags}, 32'd0);
    check_eq("arst_rdcnt", {16'b0, read_count}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // reset again at sweep index 100
    repeat (100) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    wait_sweep("sweep2");

    access(32'hE0, 1'b1, 1'b0, 0, 1'b0);
    check_eq("rd_E0_cleared", rd_sample, 32'h0);
    check_eq("rdcnt_after_rst", {16'b0, read_count}, 32'd1);

    // read counter saturation
    data_address = 32'h0;
    data_read    = 1'b1;
    repeat (65533) @(posedge clk);
    #1;
    check_eq("rdcnt_FFFE", {16'b0, read_count}, 32'h0000_FFFE);
    @(posedge clk);
    #1;
    check_eq("rdcnt_FFFF", {16'b0, read_count}, 32'h0000_FFFF);
    repeat (4470) @(posedge clk);
    #1;
    data_read = 1'b0;
    check_eq("rdcnt_sat", {16'b0, read_count}, 32'h0000_FFFF);
    check_eq("wrcnt_sat_idle", {16'b0, write_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
